// File: rtl/inst_prefetch_buf_pkg.sv
// rtl/inst_prefetch_buf_pkg.sv - shared fetch widths, PC step and reset PC for the prefetch buffer
package inst_prefetch_buf_pkg;

    // Instruction address bus width, default for ADDR_W
    localparam int INST_ADDR_BUS = 32;

    // Instruction bus width, default for DATA_W
    localparam int INST_BUS = 32;

    // Byte step between sequential instructions
    localparam int DEF_PC_INCR = 4;

    // First fetch address after reset
    localparam logic [INST_ADDR_BUS-1:0] DEF_RESET_PC = '0;

endpackage

// File: rtl/inst_prefetch_buf_sync_fifo.sv
// rtl/inst_prefetch_buf_sync_fifo.sv - synchronous FIFO with clear, count and combinational head read
module sync_fifo #(
    parameter  int WIDTH = 64,
    parameter  int DEPTH = 4,
    localparam int AW    = $clog2(DEPTH),
    localparam int CW    = AW + 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clear_i,
    input  logic             push_i,
    input  logic [WIDTH-1:0] push_data_i,
    input  logic             pop_i,
    output logic [WIDTH-1:0] head_o,
    output logic [CW-1:0]    count_o,
    output logic             empty_o
);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]    count_q, count_d;
    logic             full;
    logic             do_push;
    logic             do_pop;

    assign full    = (count_q == CW'(DEPTH));
    assign empty_o = (count_q == '0);
    assign count_o = count_q;
    assign head_o  = mem_q[rd_ptr_q];

    // A clear wins over push and pop; writes into a full FIFO and reads from an empty one are ignored
    assign do_push = push_i && !full && !clear_i;
    assign do_pop  = pop_i && !empty_o && !clear_i;

    // Pointer and occupancy next-state
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (clear_i) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (do_push) wr_ptr_d = wr_ptr_q + AW'(1);
            if (do_pop)  rd_ptr_d = rd_ptr_q + AW'(1);
            count_d = count_q + CW'(do_push) - CW'(do_pop);
        end
    end

    // Pointer and occupancy registers
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Entry storage; contents are don't-care while the slot is not counted
    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_ptr_q] <= push_data_i;
    end

endmodule

// File: rtl/inst_prefetch_buf.sv
// rtl/inst_prefetch_buf.sv - instruction prefetch queue with credit-limited fetch and redirect flush
module inst_prefetch_buf
    import inst_prefetch_buf_pkg::*;
#(
    parameter int              ADDR_W   = INST_ADDR_BUS,
    parameter int              DATA_W   = INST_BUS,
    parameter int              DEPTH    = 4,
    parameter logic [ADDR_W-1:0] RESET_PC = ADDR_W'(DEF_RESET_PC),
    parameter int              PC_INCR  = DEF_PC_INCR
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              redirect_i,
    input  logic [ADDR_W-1:0] redirect_pc_i,
    input  logic              core_ready_i,
    output logic [DATA_W-1:0] inst_o,
    output logic [ADDR_W-1:0] inst_pc_o,
    output logic              inst_valid_o,
    output logic              rom_ce_o,
    output logic [ADDR_W-1:0] rom_addr_o,
    input  logic              rom_gnt_i,
    input  logic [DATA_W-1:0] rom_data_i,
    input  logic              rom_rvalid_i
);

    localparam int CW = $clog2(DEPTH) + 1;
    localparam int EW = ADDR_W + DATA_W;

    logic [ADDR_W-1:0] fetch_pc_q, fetch_pc_d;
    logic [ADDR_W-1:0] resp_pc_q, resp_pc_d;
    logic [CW-1:0]     outst_q, outst_d;
    logic [CW-1:0]     drop_q, drop_d;

    logic [CW-1:0]     fifo_count;
    logic              fifo_empty;
    logic [EW-1:0]     fifo_head;
    logic [CW:0]       credits_used;
    logic              accept;
    logic              rv_ok;
    logic              fifo_push;
    logic              fifo_pop;

    // Every slot is either occupied or reserved by a granted request, so pushes never overflow
    assign credits_used = {1'b0, outst_q} + {1'b0, fifo_count};
    assign rom_ce_o     = !rst && !redirect_i && (credits_used < (CW+1)'(DEPTH));
    assign rom_addr_o   = fetch_pc_q;
    assign accept       = rom_ce_o && rom_gnt_i;

    // A response with nothing outstanding is a protocol error and is ignored entirely
    assign rv_ok     = rom_rvalid_i && (outst_q != '0);
    assign fifo_push = rv_ok && !redirect_i && (drop_q == '0);
    assign fifo_pop  = core_ready_i && inst_valid_o && !redirect_i;

    assign inst_valid_o = !fifo_empty;
    assign inst_o       = fifo_empty ? '0 : fifo_head[DATA_W-1:0];
    assign inst_pc_o    = fifo_empty ? resp_pc_q : fifo_head[EW-1:DATA_W];

    sync_fifo #(
        .WIDTH (EW),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk         (clk),
        .rst         (rst),
        .clear_i     (redirect_i),
        .push_i      (fifo_push),
        .push_data_i ({resp_pc_q, rom_data_i}),
        .pop_i       (fifo_pop),
        .head_o      (fifo_head),
        .count_o     (fifo_count),
        .empty_o     (fifo_empty)
    );

    // Fetch/response address, in-flight and discard counter next-state
    always_comb begin
        fetch_pc_d = fetch_pc_q;
        resp_pc_d  = resp_pc_q;
        drop_d     = drop_q;
        outst_d    = outst_q + CW'(accept) - CW'(rv_ok);
        if (redirect_i) begin
            fetch_pc_d = redirect_pc_i;
            resp_pc_d  = redirect_pc_i;
            drop_d     = outst_d;
        end else begin
            if (accept)    fetch_pc_d = fetch_pc_q + ADDR_W'(PC_INCR);
            if (fifo_push) resp_pc_d  = resp_pc_q + ADDR_W'(PC_INCR);
            if (rv_ok && (drop_q != '0)) drop_d = drop_q - CW'(1);
        end
    end

    // Address and counter registers
    always_ff @(posedge clk) begin
        if (rst) begin
            fetch_pc_q <= RESET_PC;
            resp_pc_q  <= RESET_PC;
            outst_q    <= '0;
            drop_q     <= '0;
        end else begin
            fetch_pc_q <= fetch_pc_d;
            resp_pc_q  <= resp_pc_d;
            outst_q    <= outst_d;
            drop_q     <= drop_d;
        end
    end

endmodule
